// File: rtl/ex_stage.sv
// Execute stage of the five-stage RISC-V pipeline.
// Computes ALU results, resolves branches and jumps, and registers everything
// straight into the EX/MEM boundary. MUL/DIVU/REMU share one 32-iteration
// sequential unit and hold the upstream pipeline through stall_out.
//
// Ports:
//   clock, reset                 clock and synchronous active-low reset
//   data_in_1, data_in_2         rs1 / rs2 values
//   imm_in, pipe_pc_in           immediate and PC of the instruction
//   rd_in, pcsrc_in, alusrc_in   destination, jump marker, operand-B select
//   memtoreg_in, we_in, reg_en_in control passthrough
//   aluop_in, br_in              operation code, conditional-branch marker
//   *_out                        registered EX/MEM outputs
//   stall_out                    combinational hold request for upstream
module ex_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] data_in_1,
  input  logic [XLEN-1:0] data_in_2,
  input  logic [XLEN-1:0] imm_in,
  input  logic [4:0]      rd_in,
  input  logic            pcsrc_in,
  input  logic            alusrc_in,
  input  logic            memtoreg_in,
  input  logic            we_in,
  input  logic            reg_en_in,
  input  logic [5:0]      aluop_in,
  input  logic            br_in,
  input  logic [XLEN-1:0] pipe_pc_in,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] store_data_out,
  output logic [4:0]      rd_out,
  output logic            memtoreg_out,
  output logic            we_out,
  output logic            reg_en_out,
  output logic            branch_taken_out,
  output logic [XLEN-1:0] branch_target_out,
  output logic            stall_out
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  // op_a: multiplicand (shifts left) or divisor; op_b: multiplier (shifts
  // right) or dividend turning into quotient; acc: product or remainder.
  logic [XLEN-1:0] op_a_q, op_a_d, op_b_q, op_b_d, acc_q, acc_d;
  logic            is_mul_q, is_mul_d, is_rem_q, is_rem_d;

  logic [XLEN-1:0] res_q, res_d, store_q, store_d, tgt_q, tgt_d;
  logic [4:0]      rd_q, rd_d;
  logic            mtr_q, mtr_d, we_q, we_d, ren_q, ren_d, taken_q, taken_d;

  logic [XLEN-1:0] opb, alu_res, pc_imm, rem_next;
  logic [XLEN:0]   trial, diff;
  logic            is_multi, br_cond, ge;

  assign opb      = alusrc_in ? imm_in : data_in_2;
  assign pc_imm   = pipe_pc_in + imm_in;
  assign is_multi = (aluop_in == 6'd11) || (aluop_in == 6'd12) || (aluop_in == 6'd13);

  // Held low while reset is asserted so upstream never freezes during reset.
  assign stall_out = reset && (((state_q == StIdle) && is_multi) || (state_q == StBusy));

  always_comb begin
    alu_res = '0;
    case (aluop_in)
      6'd0:    alu_res = data_in_1 + opb;
      6'd1:    alu_res = data_in_1 - opb;
      6'd2:    alu_res = data_in_1 & opb;
      6'd3:    alu_res = data_in_1 | opb;
      6'd4:    alu_res = data_in_1 ^ opb;
      6'd5:    alu_res = data_in_1 << opb[4:0];
      6'd6:    alu_res = data_in_1 >> opb[4:0];
      6'd7:    alu_res = $unsigned($signed(data_in_1) >>> opb[4:0]);
      6'd8:    alu_res = {{(XLEN-1){1'b0}}, $signed(data_in_1) < $signed(opb)};
      6'd9:    alu_res = {{(XLEN-1){1'b0}}, data_in_1 < opb};
      6'd10:   alu_res = opb;
      default: alu_res = '0;
    endcase
  end

  // Branch compares always use rs2, never the immediate.
  always_comb begin
    br_cond = 1'b0;
    case (aluop_in)
      6'd16:   br_cond = data_in_1 == data_in_2;
      6'd17:   br_cond = data_in_1 != data_in_2;
      6'd18:   br_cond = $signed(data_in_1) < $signed(data_in_2);
      6'd19:   br_cond = $signed(data_in_1) >= $signed(data_in_2);
      6'd20:   br_cond = data_in_1 < data_in_2;
      6'd21:   br_cond = data_in_1 >= data_in_2;
      default: br_cond = 1'b0;
    endcase
  end

  // Restoring divide step. A zero divisor always "fits", which naturally
  // yields an all-ones quotient and leaves the dividend as remainder.
  always_comb begin
    trial    = {acc_q, op_b_q[XLEN-1]};
    diff     = trial - {1'b0, op_a_q};
    ge       = trial >= {1'b0, op_a_q};
    rem_next = ge ? diff[XLEN-1:0] : trial[XLEN-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    acc_d    = acc_q;
    is_mul_d = is_mul_q;
    is_rem_d = is_rem_q;
    res_d    = '0;
    store_d  = '0;
    tgt_d    = '0;
    rd_d     = '0;
    mtr_d    = 1'b0;
    we_d     = 1'b0;
    ren_d    = 1'b0;
    taken_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (is_multi) begin
          state_d  = StBusy;
          cnt_d    = '0;
          acc_d    = '0;
          is_mul_d = aluop_in == 6'd11;
          is_rem_d = aluop_in == 6'd13;
          op_a_d   = (aluop_in == 6'd11) ? data_in_1 : opb;
          op_b_d   = (aluop_in == 6'd11) ? opb : data_in_1;
        end else begin
          store_d = data_in_2;
          rd_d    = rd_in;
          mtr_d   = memtoreg_in;
          we_d    = we_in;
          ren_d   = reg_en_in;
          if (pcsrc_in) begin
            res_d   = pipe_pc_in + XLEN'(4);
            taken_d = 1'b1;
            tgt_d   = pc_imm;
          end else if (br_in) begin
            taken_d = br_cond;
            tgt_d   = br_cond ? pc_imm : '0;
          end else begin
            res_d = alu_res;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q + 5'd1;
        if (is_mul_q) begin
          acc_d  = acc_q + (op_b_q[0] ? op_a_q : '0);
          op_a_d = op_a_q << 1;
          op_b_d = op_b_q >> 1;
        end else begin
          acc_d  = rem_next;
          op_b_d = {op_b_q[XLEN-2:0], ge};
        end
        if (cnt_q == 5'd31) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
        res_d   = (is_mul_q || is_rem_q) ? acc_q : op_b_q;
        store_d = data_in_2;
        rd_d    = rd_in;
        mtr_d   = memtoreg_in;
        we_d    = we_in;
        ren_d   = reg_en_in;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      acc_q    <= '0;
      is_mul_q <= 1'b0;
      is_rem_q <= 1'b0;
      res_q    <= '0;
      store_q  <= '0;
      tgt_q    <= '0;
      rd_q     <= '0;
      mtr_q    <= 1'b0;
      we_q     <= 1'b0;
      ren_q    <= 1'b0;
      taken_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      acc_q    <= acc_d;
      is_mul_q <= is_mul_d;
      is_rem_q <= is_rem_d;
      res_q    <= res_d;
      store_q  <= store_d;
      tgt_q    <= tgt_d;
      rd_q     <= rd_d;
      mtr_q    <= mtr_d;
      we_q     <= we_d;
      ren_q    <= ren_d;
      taken_q  <= taken_d;
    end
  end

  assign alu_result_out    = res_q;
  assign store_data_out    = store_q;
  assign rd_out            = rd_q;
  assign memtoreg_out      = mtr_q;
  assign we_out            = we_q;
  assign reg_en_out        = ren_q;
  assign branch_taken_out  = taken_q;
  assign branch_target_out = tgt_q;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  logic        clock, reset;
  logic [31:0] data_in_1, data_in_2, imm_in, pipe_pc_in;
  logic [4:0]  rd_in;
  logic        pcsrc_in, alusrc_in, memtoreg_in, we_in, reg_en_in, br_in;
  logic [5:0]  aluop_in;
  logic [31:0] alu_result_out, store_data_out, branch_target_out;
  logic [4:0]  rd_out;
  logic        memtoreg_out, we_out, reg_en_out, branch_taken_out, stall_out;

  ex_stage #(.XLEN(32)) dut (
    .clock(clock), .reset(reset),
    .data_in_1(data_in_1), .data_in_2(data_in_2), .imm_in(imm_in), .rd_in(rd_in),
    .pcsrc_in(pcsrc_in), .alusrc_in(alusrc_in), .memtoreg_in(memtoreg_in),
    .we_in(we_in), .reg_en_in(reg_en_in), .aluop_in(aluop_in), .br_in(br_in),
    .pipe_pc_in(pipe_pc_in), .alu_result_out(alu_result_out),
    .store_data_out(store_data_out), .rd_out(rd_out), .memtoreg_out(memtoreg_out),
    .we_out(we_out), .reg_en_out(reg_en_out), .branch_taken_out(branch_taken_out),
    .branch_target_out(branch_target_out), .stall_out(stall_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] store;
    logic [4:0]  rd;
    logic        mtr, we, ren, taken;
    logic [31:0] tgt;
  } out_t;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] a, b, imm, pc;
    logic        alusrc, br, pcsrc;
    logic [4:0]  rd;
    logic [2:0]  ctl;  // {memtoreg, we, reg_en}
    out_t        exp;
  } vec_t;

  vec_t  vecs[$];
  out_t  exp_q[$];
  string name_q[$];
  int    tests = 0;
  int    fails = 0;

  function automatic vec_t mk(string n, logic [5:0] op, logic [31:0] a, logic [31:0] b,
                              logic [31:0] imm, logic alusrc, logic br, logic pcsrc,
                              logic [31:0] pc, logic [4:0] rd, logic [2:0] ctl,
                              logic [31:0] res, logic tk, logic [31:0] tgt);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b; v.imm = imm; v.pc = pc;
    v.alusrc = alusrc; v.br = br; v.pcsrc = pcsrc; v.rd = rd; v.ctl = ctl;
    v.exp = '{res: res, store: b, rd: rd, mtr: ctl[2], we: ctl[1], ren: ctl[0],
              taken: tk, tgt: tgt};
    return v;
  endfunction

  function automatic out_t actual();
    out_t o;
    o = '{res: alu_result_out, store: store_data_out, rd: rd_out, mtr: memtoreg_out,
          we: we_out, ren: reg_en_out, taken: branch_taken_out, tgt: branch_target_out};
    return o;
  endfunction

  task automatic check_out(string name, out_t got, out_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic check_val(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic drive(vec_t v);
    data_in_1 = v.a; data_in_2 = v.b; imm_in = v.imm; pipe_pc_in = v.pc;
    aluop_in = v.op; alusrc_in = v.alusrc; br_in = v.br; pcsrc_in = v.pcsrc;
    rd_in = v.rd; {memtoreg_in, we_in, reg_en_in} = v.ctl;
  endtask

  task automatic pop_check();
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard: got output with empty queue, required a pending entry");
    end else begin
      check_out(name_q.pop_front(), actual(), exp_q.pop_front());
    end
  endtask

  task automatic run_single(vec_t v);
    drive(v);
    exp_q.push_back(v.exp);
    name_q.push_back(v.name);
    #1;
    check_val({v.name, "_stall"}, {31'b0, stall_out}, 32'd0);
    @(posedge clock); #1;
    pop_check();
  endtask

  task automatic run_multi(string n, logic [5:0] op, logic [31:0] a, logic [31:0] b,
                           logic [31:0] imm, logic alusrc, logic [31:0] res);
    vec_t v;
    int   stalls;
    logic bubble_bad;
    v = mk(n, op, a, b, imm, alusrc, 1'b0, 1'b0, 32'h0, 5'd7, 3'b001, res, 1'b0, 32'h0);
    drive(v);
    exp_q.push_back(v.exp);
    name_q.push_back(v.name);
    #1;
    stalls = 0;
    bubble_bad = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (!stall_out) break;
      stalls++;
      @(posedge clock); #1;
      if (actual() !== '0) bubble_bad = 1'b1;
    end
    check_val({n, "_stall_cycles"}, stalls, 32'd33);
    check_val({n, "_bubbles"}, {31'b0, bubble_bad}, 32'd0);
    @(posedge clock); #1;
    pop_check();
  endtask

  task automatic idle_inputs();
    data_in_1 = '0; data_in_2 = '0; imm_in = '0; pipe_pc_in = '0; aluop_in = '0;
    alusrc_in = 0; br_in = 0; pcsrc_in = 0; rd_in = '0;
    {memtoreg_in, we_in, reg_en_in} = 3'b000;
  endtask

  initial begin
    vec_t add_v;
    idle_inputs();
    aluop_in = 6'd11;  // a multi-cycle code present during reset must not stall
    reset = 1'b0;
    #1;
    check_val("stall_in_reset", {31'b0, stall_out}, 32'd0);
    @(posedge clock); #1;
    check_out("reset_outputs", actual(), '0);
    check_val("stall_after_reset_edge", {31'b0, stall_out}, 32'd0);
    idle_inputs();
    reset = 1'b1;

    vecs.push_back(mk("add_imm", 0, 5, 0, 7, 1, 0, 0, 0, 3, 3'b001, 12, 0, 0));
    vecs.push_back(mk("add_store", 0, 32'h1000, 32'hDEADBEEF, 8, 1, 0, 0, 0, 0, 3'b010,
                      32'h1008, 0, 0));
    vecs.push_back(mk("sub", 1, 5, 7, 0, 0, 0, 0, 0, 4, 3'b001, 32'hFFFFFFFE, 0, 0));
    vecs.push_back(mk("and", 2, 32'hF0F0, 32'hFF00, 0, 0, 0, 0, 0, 5, 3'b001, 32'hF000, 0, 0));
    vecs.push_back(mk("or", 3, 32'hF0F0, 32'hFF00, 0, 0, 0, 0, 0, 5, 3'b001, 32'hFFF0, 0, 0));
    vecs.push_back(mk("xor", 4, 32'hF0F0, 32'hFF00, 0, 0, 0, 0, 0, 5, 3'b001, 32'h0FF0, 0, 0));
    vecs.push_back(mk("sll_amt5", 5, 1, 36, 0, 0, 0, 0, 0, 6, 3'b001, 16, 0, 0));
    vecs.push_back(mk("srl", 6, 32'h80000000, 4, 0, 0, 0, 0, 0, 6, 3'b001, 32'h08000000, 0, 0));
    vecs.push_back(mk("sra", 7, 32'h80000000, 0, 4, 1, 0, 0, 0, 6, 3'b001, 32'hF8000000, 0, 0));
    vecs.push_back(mk("slt", 8, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 8, 3'b001, 1, 0, 0));
    vecs.push_back(mk("sltu", 9, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 8, 3'b001, 0, 0, 0));
    vecs.push_back(mk("passb", 10, 5, 0, 32'h12345000, 1, 0, 0, 0, 9, 3'b101,
                      32'h12345000, 0, 0));
    vecs.push_back(mk("unlisted", 15, 5, 7, 0, 0, 0, 0, 0, 9, 3'b001, 0, 0, 0));
    vecs.push_back(mk("blt_taken", 18, 32'hFFFFFFFF, 1, 32'h20, 0, 1, 0, 32'h100, 0, 3'b000,
                      0, 1, 32'h120));
    vecs.push_back(mk("bltu_not", 20, 32'hFFFFFFFF, 1, 32'h20, 0, 1, 0, 32'h100, 0, 3'b000,
                      0, 0, 0));
    vecs.push_back(mk("beq_taken", 16, 9, 9, 32'h40, 1, 1, 0, 32'h200, 0, 3'b000,
                      0, 1, 32'h240));
    vecs.push_back(mk("bne_not", 17, 9, 9, 32'h40, 1, 1, 0, 32'h200, 0, 3'b000, 0, 0, 0));
    vecs.push_back(mk("bge_taken", 19, 1, 32'hFFFFFFFF, 32'hFFFFFFF0, 0, 1, 0, 32'h300, 0,
                      3'b000, 0, 1, 32'h2F0));
    vecs.push_back(mk("bgeu_not", 21, 1, 32'hFFFFFFFF, 32'hFFFFFFF0, 0, 1, 0, 32'h300, 0,
                      3'b000, 0, 0, 0));
    vecs.push_back(mk("br_noncode", 0, 1, 2, 32'h40, 0, 1, 0, 32'h300, 0, 3'b000, 0, 0, 0));
    vecs.push_back(mk("jal", 0, 0, 0, 32'h20, 0, 0, 1, 32'h100, 1, 3'b001,
                      32'h104, 1, 32'h120));
    vecs.push_back(mk("jal_over_br", 17, 9, 9, 32'h20, 0, 1, 1, 32'h100, 1, 3'b001,
                      32'h104, 1, 32'h120));

    @(posedge clock); #1;
    foreach (vecs[i]) run_single(vecs[i]);

    run_multi("mul", 11, 1234, 5678, 0, 0, 32'h006AE9BC);
    run_multi("divu_by0", 12, 100, 0, 0, 0, 32'hFFFFFFFF);
    run_multi("remu_by0", 13, 100, 0, 0, 0, 100);
    run_multi("divu", 12, 100, 7, 0, 0, 14);
    run_multi("remu_imm", 13, 100, 0, 7, 1, 2);
    run_multi("mul_wrap", 11, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1);
    idle_inputs();

    // Abort a multiply at counter 10 with an ADD waiting upstream.
    run_single(mk("pre_abort", 0, 1, 1, 0, 0, 0, 0, 0, 2, 3'b001, 2, 0, 0));
    drive(mk("mul_abort", 11, 1234, 5678, 0, 0, 0, 0, 0, 7, 3'b001, 0, 0, 0));
    repeat (11) @(posedge clock);
    #1;
    add_v = mk("add_after_reset", 0, 5, 0, 7, 1, 0, 0, 0, 3, 3'b001, 12, 0, 0);
    drive(add_v);
    reset = 1'b0;
    #1;
    check_val("stall_reset_busy", {31'b0, stall_out}, 32'd0);
    @(posedge clock); #1;
    check_out("abort_outputs", actual(), '0);
    check_val("stall_after_abort", {31'b0, stall_out}, 32'd0);
    reset = 1'b1;
    exp_q.push_back(add_v.exp);
    name_q.push_back(add_v.name);
    @(posedge clock); #1;
    pop_check();
    check_val("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage RISC-V pipeline. It consumes the registered ID/EX bundle and computes the ALU result, branch/jump resolution and store data. It registers everything into the EX/MEM boundary, so no separate EX/MEM register is needed. Single-cycle ops complete in one clock. MUL/DIVU/REMU run on a shared 32-iteration sequential unit and hold the upstream pipeline with `stall_out`.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clock  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  one clock; reset is synchronous and active-low.
- data_in_1  in  32  rs1 value.
- data_in_2  in  32  rs2 value.
- imm_in  in  32  sign-extended immediate.
- rd_in  in  5  destination register.
- pcsrc_in  in  1  jump (JAL) marker.
- alusrc_in  in  1  1 selects imm_in as operand B; 0 selects data_in_2.
- memtoreg_in, we_in, reg_en_in  in  1 each  control passthrough.
- aluop_in  in  6  operation code.
- br_in  in  1  conditional branch marker.
- pipe_pc_in  in  32  PC of the instruction.
- alu_result_out  out  32  result or memory address.
- store_data_out  out  32  registered data_in_2.
- rd_out  out  5  registered rd.
- memtoreg_out, we_out, reg_en_out  out  1 each  registered control.
- branch_taken_out  out  1  redirect fetch.
- branch_target_out  out  32  redirect address.
- stall_out  out  1  combinational; while 1, upstream stages and ID/EX must hold their contents.

## Operation
- Operand B = alusrc_in ? imm_in : data_in_2. All arithmetic is modulo 2^32.
- aluop_in single-cycle codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount is B[4:0].
  - 8 SLT (signed), 9 SLTU; result is 0 or 1.
  - 10 PASSB (LUI).
  - Any unlisted code gives result 0.
- aluop_in multi-cycle codes: 11 MUL (low 32 bits), 12 DIVU, 13 REMU.
  - Divide by zero: DIVU gives 0xFFFFFFFF; REMU gives the dividend.
- Branch, when br_in=1: aluop_in selects 16 BEQ, 17 BNE, 18 BLT, 19 BGE, 20 BLTU, 21 BGEU.
  - The compare is data_in_1 vs data_in_2, ignoring alusrc_in.
  - Taken gives branch_taken_out=1 and branch_target_out=pipe_pc_in+imm_in.
  - alu_result_out=0 for branches.
- Jump, when pcsrc_in=1: branch_taken_out=1, branch_target_out=pipe_pc_in+imm_in, alu_result_out=pipe_pc_in+4. pcsrc_in takes priority over br_in.
- A not-taken or non-branch op gives branch_taken_out=0 and branch_target_out=0.
- FSM states: IDLE, BUSY, DONE. A 5-bit iteration counter is used in BUSY.
  - IDLE, multi-cycle code present: stall_out=1. At the edge, latch operands, counter←0, go to BUSY, and register a bubble.
  - IDLE, any other op: stall_out=0. At the edge, register the op result.
  - BUSY: stall_out=1. Each edge performs one iteration: shift-add multiply, or restoring divide.
    - Counter increments each edge.
    - After iteration with counter=31, go to DONE.
    - A bubble is registered every BUSY edge.
  - DONE: stall_out=0. The held ID/EX inputs are still present. At the edge, register the unit result with the held control signals, then go to IDLE.
- Bubble definition: reg_en_out=0, we_out=0, memtoreg_out=0, branch_taken_out=0. All other outputs are 0.
- The multi-cycle op is identified only by aluop_in; reg_en_in does not gate it.

## Timing
- Reset (reset=0 at an edge): every output register becomes 0. The FSM goes to IDLE and the counter to 0.
  - stall_out=0 during and after reset.
  - Reset in BUSY or DONE aborts the op; nothing is written.
- Single-cycle op latency: outputs reflect inputs after 1 rising edge.
- Multi-cycle op presented at cycle 0:
  - stall_out=1 for cycles 0..32 (33 cycles) and 0 in cycle 33 (DONE).
  - The result is visible after edge 34.
  - A back-to-back multi-cycle op follows from IDLE with no extra gap.
- Branch and jump outputs are registered, so fetch sees the redirect 1 edge after EX sampling. Flushing is the consumer's job.

## Test plan
- ADD: data_in_1=5, imm_in=7, alusrc_in=1, aluop=0, rd_in=3, reg_en_in=1 -> after 1 edge: alu_result_out=12, rd_out=3, reg_en_out=1, stall_out=0 throughout.
- SRA and SLT: data_in_1=0x80000000, B=4, aluop=7 -> 0xF8000000. Then SLT of 0xFFFFFFFF vs 1 -> 1, while SLTU of the same operands -> 0.
- BLT: br_in=1, aluop=18, data_in_1=0xFFFFFFFF, data_in_2=1, pipe_pc_in=0x100, imm_in=0x20 -> branch_taken_out=1, branch_target_out=0x120. Then JAL at the same PC -> alu_result_out=0x104, taken=1.
- MUL: 1234×5678, aluop=11 -> stall_out high exactly 33 cycles, bubbles registered during the stall, alu_result_out=0x006AE9BC after edge 34.
- DIVU/REMU: 100÷0 -> 0xFFFFFFFF and 100. Then 100÷7 -> 14 and 2.
- Reset mid-op: reset=0 at BUSY counter=10 -> next cycle all outputs 0, stall_out=0. After release, an ADD completes in 1 cycle.
